// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit start check,
// centre sampling of 8 data bits, stop-bit check with break hold-off.
module uart_rx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_d;
  logic          rxd_m, rxd_s;
  logic [CW-1:0] clk_cnt, cnt_d;
  logic [2:0]    bit_idx, idx_d;
  logic [7:0]    shift_reg, shift_d;
  logic [7:0]    data_d;
  logic          valid_d, err_d;

  // Two-stage synchroniser; idles high so reset never looks like a start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // State, datapath and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_d;
      clk_cnt      <= cnt_d;
      bit_idx      <= idx_d;
      shift_reg    <= shift_d;
      rx_data      <= data_d;
      rx_valid     <= valid_d;
      rx_frame_err <= err_d;
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d = state;
    cnt_d   = clk_cnt;
    idx_d   = bit_idx;
    shift_d = shift_reg;
    data_d  = rx_data;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) begin
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d = clk_cnt + CW'(1);
        if (clk_cnt == HALF_M1) begin
          cnt_d = '0;
          idx_d = '0;
          if (!rxd_s) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        cnt_d = clk_cnt + CW'(1);
        if (clk_cnt == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_reg[7:1]};
          if (bit_idx == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        cnt_d = clk_cnt + CW'(1);
        if (clk_cnt == BIT_M1) begin
          cnt_d = '0;
          if (rxd_s) begin
            data_d  = shift_reg;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxd_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: serialises frames onto rxd and
// compares received events against a frame-level expectation queue.
module tb_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         cyc;
  int         n_chk;
  int         n_pass;
  int         both_hi;
  int         long_pulse;
  bit         pv;
  bit         pe;
  logic [7:0] model_data;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid && rx_frame_err) both_hi++;
    if ((rx_valid && pv) || (rx_frame_err && pe)) long_pulse++;
    pv = rx_valid;
    pe = rx_frame_err;
    if (rx_valid)
      obs_q.push_back('{err: 1'b0, data: rx_data, t: cyc});
    if (rx_frame_err)
      obs_q.push_back('{err: 1'b1, data: 8'h00, t: cyc});
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // tp = bit period in tenths of a clock; rst_bit pulses reset mid-bit
  // and abandons the frame, leaving the line idle.
  task automatic send_frame(logic [7:0] b, bit stop, int tp,
                            int rst_bit = -1);
    logic [9:0] fr;
    int prev;
    int e;
    fr = {stop, b, 1'b0};
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      rxd = fr[k];
      e = ((k + 1) * tp) / 10;
      if (k == rst_bit) begin
        cycles((e - prev) / 2);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        rxd = 1'b1;
        model_data = 8'h00;
        return;
      end
      cycles(e - prev);
      prev = e;
    end
    if (stop) begin
      exp_q.push_back('{err: 1'b0, data: b, t: 0});
      model_data = b;
    end else begin
      exp_q.push_back('{err: 1'b1, data: 8'h00, t: 0});
    end
  endtask

  task automatic drain(string tag);
    int w;
    int n;
    cycles(4);
    w = 0;
    while (rx_busy && w < 400) begin
      cycles(1);
      w++;
    end
    chk({tag, "_idle"}, {31'd0, rx_busy}, 32'd0);
    chk({tag, "_nev"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_kind"}, {31'd0, obs_q[i].err}, {31'd0, exp_q[i].err});
      if (!exp_q[i].err)
        chk({tag, "_data"}, {24'd0, obs_q[i].data},
            {24'd0, exp_q[i].data});
    end
    chk({tag, "_hold"}, {24'd0, rx_data}, {24'd0, model_data});
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit   b;
    int   gap;
    logic [7:0] rb;
    bit   rs;
    model_data = 8'h00;

    cycles(3);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_err", {31'd0, rx_frame_err}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    rst_n = 1'b1;
    cycles(5);

    send_frame(8'hA5, 1'b1, 100);
    cycles(10);
    drain("a5");

    rxd = 1'b0;
    cycles(3);
    b = rx_busy;
    rxd = 1'b1;
    chk("glitch_busy", {31'd0, b}, 32'd1);
    drain("glitch");

    send_frame(8'h3C, 1'b0, 100);
    cycles(30);
    chk("brk_busy", {31'd0, rx_busy}, 32'd1);
    rxd = 1'b1;
    cycles(10);
    drain("brk");

    send_frame(8'h00, 1'b1, 100);
    send_frame(8'hFF, 1'b1, 100);
    cycles(6);
    gap = (obs_q.size() >= 2) ? obs_q[1].t - obs_q[0].t : -1;
    chk("b2b_gap", {31'd0, (gap >= 99 && gap <= 101)}, 32'd1);
    drain("b2b");

    send_frame(8'h5A, 1'b1, 100, 5);
    chk("abort_data", {24'd0, rx_data}, 32'd0);
    chk("abort_busy", {31'd0, rx_busy}, 32'd0);
    cycles(30);
    send_frame(8'h81, 1'b1, 100);
    cycles(10);
    drain("abort");

    send_frame(8'h96, 1'b1, 102);
    cycles(10);
    drain("slow");

    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rb, rs, $urandom_range(98, 102));
      rxd = 1'b1;
      gap = rs ? $urandom_range(0, 15) : $urandom_range(25, 40);
      cycles(gap);
    end
    cycles(10);
    drain("rand");

    chk("never_both", both_hi, 32'd0);
    chk("one_cycle", long_pulse, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
